// File: rtl/decode_unit.sv
// RV instruction decode stage: one pipeline register plus a one-entry skid buffer.
// in_ready is registered so that it does not depend combinationally on out_ready.
module decode_unit #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam int DW = 2*XLEN + 36;
   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [2:0]      fmt;
   logic [2:0]      d_fmt;
   logic            known;
   logic            ill;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm;
   logic [DW-1:0]   dec;
   logic [DW-1:0]   main_q;
   logic [DW-1:0]   skid_q;
   logic            main_valid;
   logic            skid_valid;
   logic            in_fire;
   logic            out_fire;

   assign opc = in_inst[6:0];
   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];

   always_comb begin
      fmt   = FMT_R;
      known = 1'b1;
      case (opc)
         7'b0110111, 7'b0010111: fmt = FMT_U;
         7'b1101111:             fmt = FMT_J;
         7'b1100011:             fmt = FMT_B;
         7'b0100011:             fmt = FMT_S;
         7'b0110011, 7'b0111011: fmt = FMT_R;
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0011011, 7'b0001111, 7'b1110011: fmt = FMT_I;
         default: known = 1'b0;
      endcase
      ill = (in_inst[1:0] != 2'b11) || !known ||
            (fmt == FMT_R && !(f7 == 7'b0000000 || f7 == 7'b0100000 || f7 == 7'b0000001));
      d_fmt = fmt;
      rd    = in_inst[11:7];
      rs1   = in_inst[19:15];
      rs2   = in_inst[24:20];
      imm   = '0;
      case (fmt)
         FMT_I: begin
            imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            rs2 = '0;
         end
         FMT_S: begin
            imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            rd  = '0;
         end
         FMT_B: begin
            imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
            rd  = '0;
         end
         FMT_U: begin
            imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
            rs1 = '0;
            rs2 = '0;
         end
         FMT_J: begin
            imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                   in_inst[20], in_inst[30:21], 1'b0};
            rs1 = '0;
            rs2 = '0;
         end
         default: ;
      endcase
      // Illegal instructions keep only their raw identifying fields.
      if (ill) begin
         rd    = '0;
         rs1   = '0;
         rs2   = '0;
         imm   = '0;
         d_fmt = FMT_R;
      end
   end

   assign dec = {in_pc, opc, f3, f7, rd, rs1, rs2, imm, d_fmt, ill};

   assign in_fire  = in_valid && in_ready;
   assign out_fire = main_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         if (!main_valid || out_fire) begin
            if (skid_valid) begin
               main_q     <= skid_q;
               main_valid <= 1'b1;
            end else if (in_fire) begin
               main_q     <= dec;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end
         // Skid only fills when main is occupied and stalled.
         if (in_fire && main_valid && !out_fire) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
         end else if (skid_valid && out_fire) begin
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
         end
      end
   end

   assign out_valid = main_valid;
   assign {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
           out_imm, out_fmt, out_illegal} = main_q;

endmodule

// File: tb/tb_decode_unit.sv
// Randomized bench for decode_unit against a queue-based transaction model
// with an instruction decoder written from the base ISA field definitions.
module tb_decode_unit;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3, out_fmt;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic        out_illegal;

   decode_unit #(.XLEN(64), .ILEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } dec_t;

   dec_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic dec_t md(logic [31:0] i, logic [63:0] pc);
      dec_t d;
      int f;
      logic signed [11:0] s12;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      logic signed [31:0] s32;
      longint v;
      d = '0;
      d.pc = pc; d.opc = i[6:0]; d.f3 = i[14:12]; d.f7 = i[31:25];
      case (i[6:0])
         7'h37, 7'h17: f = 4;
         7'h6f:        f = 5;
         7'h63:        f = 3;
         7'h23:        f = 2;
         7'h33, 7'h3b: f = 0;
         7'h67, 7'h03, 7'h13, 7'h1b, 7'h0f, 7'h73: f = 1;
         default:      f = -1;
      endcase
      if (f == 0 && !(i[31:25] inside {7'd0, 7'd32, 7'd1})) f = -1;
      if (i[1:0] != 2'b11) f = -1;
      d.ill = (f < 0);
      if (!d.ill) begin
         d.fmt = 3'(f);
         d.rd  = (f == 2 || f == 3) ? 5'd0 : i[11:7];
         d.rs1 = (f == 4 || f == 5) ? 5'd0 : i[19:15];
         d.rs2 = (f == 0 || f == 2 || f == 3) ? i[24:20] : 5'd0;
         v = 0;
         case (f)
            1: begin s12 = i[31:20]; v = s12; end
            2: begin s12 = {i[31:25], i[11:7]}; v = s12; end
            3: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13; end
            4: begin s32 = {i[31:12], 12'h000}; v = s32; end
            5: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = s21; end
            default: v = 0;
         endcase
         d.imm = v;
      end
      return d;
   endfunction

   // One clock: update the transaction model at the edge, then check the DUT.
   task automatic tick();
      bit inf, outf;
      dec_t e;
      inf  = in_valid && in_ready;
      outf = out_valid && out_ready;
      @(posedge clk);
      if (rst || flush) q.delete();
      else begin
         if (outf && q.size() > 0) void'(q.pop_front());
         if (inf) q.push_back(md(in_inst, in_pc));
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0 && out_valid) begin
         e = q[0];
         chk("pc", out_pc, e.pc);
         chk("opcode", 64'(out_opcode), 64'(e.opc));
         chk("funct3", 64'(out_funct3), 64'(e.f3));
         chk("funct7", 64'(out_funct7), 64'(e.f7));
         chk("rd", 64'(out_rd), 64'(e.rd));
         chk("rs1", 64'(out_rs1), 64'(e.rs1));
         chk("rs2", 64'(out_rs2), 64'(e.rs2));
         chk("imm", out_imm, e.imm);
         chk("fmt", 64'(out_fmt), 64'(e.fmt));
         chk("illegal", 64'(out_illegal), 64'(e.ill));
      end
   endtask

   task automatic drv(logic v, logic [31:0] inst, logic [63:0] pc, logic ordy);
      in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy;
      tick();
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_pc"}, out_pc, 64'd0);
      chk({tag, "_imm"}, out_imm, 64'd0);
      chk({tag, "_fields"}, 64'({out_opcode, out_funct3, out_funct7, out_rd, out_rs1,
                                  out_rs2, out_fmt, out_illegal}), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   logic [6:0] opc_tbl [13] = '{7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h33, 7'h3b,
                                7'h67, 7'h03, 7'h13, 7'h1b, 7'h0f, 7'h73};

   initial begin
      logic [31:0] r;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      tick(); tick();
      chk_zero("reset");
      rst = 1'b0;

      // addi x1, x0, 5
      drv(1'b1, 32'h00500093, 64'h100, 1'b1);
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_fmt", 64'(out_fmt), 64'd1);
      chk("addi_rd", 64'(out_rd), 64'd1);
      chk("addi_rs1", 64'(out_rs1), 64'd0);
      chk("addi_rs2", 64'(out_rs2), 64'd0);
      chk("addi_imm", out_imm, 64'd5);
      chk("addi_pc", out_pc, 64'h100);
      chk("addi_ill", 64'(out_illegal), 64'd0);

      // sw x2, -4(x1)
      drv(1'b1, 32'hFE20AE23, 64'h104, 1'b1);
      chk("sw_fmt", 64'(out_fmt), 64'd2);
      chk("sw_rs1", 64'(out_rs1), 64'd1);
      chk("sw_rs2", 64'(out_rs2), 64'd2);
      chk("sw_rd", 64'(out_rd), 64'd0);
      chk("sw_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);

      drv(1'b1, 32'h00000000, 64'h200, 1'b1);
      chk("ill0_ill", 64'(out_illegal), 64'd1);
      chk("ill0_rd", 64'(out_rd), 64'd0);
      chk("ill0_imm", out_imm, 64'd0);
      chk("ill0_pc", out_pc, 64'h200);
      drv(1'b1, 32'hFE000033, 64'h204, 1'b1);
      chk("illr_ill", 64'(out_illegal), 64'd1);
      chk("illr_rd", 64'(out_rd), 64'd0);
      chk("illr_imm", out_imm, 64'd0);
      chk("illr_pc", out_pc, 64'h204);
      drv(1'b0, 32'h0, 64'h0, 1'b1);

      // Backpressure: third instruction must wait upstream.
      drv(1'b1, 32'h00100113, 64'h300, 1'b0);
      chk("bp_rdy1", 64'(in_ready), 64'd1);
      drv(1'b1, 32'h00200193, 64'h304, 1'b0);
      chk("bp_rdy2", 64'(in_ready), 64'd0);
      drv(1'b1, 32'h00300213, 64'h308, 1'b0);
      chk("bp_held_rdy", 64'(in_ready), 64'd0);
      chk("bp_held_pc", out_pc, 64'h300);
      drv(1'b1, 32'h00300213, 64'h308, 1'b1);
      chk("bp_out2", out_pc, 64'h304);
      drv(1'b1, 32'h00300213, 64'h308, 1'b1);
      chk("bp_out3", out_pc, 64'h308);
      chk("bp_out3_v", 64'(out_valid), 64'd1);
      drv(1'b0, 32'h0, 64'h0, 1'b1);
      chk("bp_done", 64'(out_valid), 64'd0);

      // Flush with both registers full and an input offered.
      drv(1'b1, 32'h00a00093, 64'h400, 1'b0);
      drv(1'b1, 32'h00b00093, 64'h404, 1'b0);
      flush = 1'b1;
      drv(1'b1, 32'h00c00093, 64'h408, 1'b0);
      flush = 1'b0;
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_rdy", 64'(in_ready), 64'd1);
      drv(1'b0, 32'h0, 64'h0, 1'b1);
      chk("fl_dropped", 64'(out_valid), 64'd0);

      // Mid-stream reset, then immediate acceptance.
      drv(1'b1, 32'h00d00093, 64'h500, 1'b0);
      drv(1'b1, 32'h00e00093, 64'h504, 1'b0);
      rst = 1'b1;
      drv(1'b1, 32'h00f00093, 64'h508, 1'b0);
      rst = 1'b0;
      chk_zero("mrst");
      drv(1'b1, 32'h01000093, 64'h50c, 1'b0);
      chk("mrst_acc_v", 64'(out_valid), 64'd1);
      chk("mrst_acc_pc", out_pc, 64'h50c);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         if ($urandom_range(7) != 0) r[6:0] = opc_tbl[$urandom_range(12)];
         if ($urandom_range(1) == 1) r[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h01;
         flush = ($urandom_range(49) == 0);
         rst   = ($urandom_range(299) == 0);
         drv($urandom_range(3) != 0, r, {$urandom, $urandom}, $urandom_range(2) != 0);
      end
      rst = 1'b0; flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
